// File: rtl/mul_div_unit_if.sv
// Command/result bundle between the decoder-side driver and the multiply/divide unit.
interface mul_div_unit_if;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDUOp, A, B,
    input  Busy, Out, HI, LO
  );

  modport slave (
    input  Start, MDUOp, A, B,
    output Busy, Out, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: holds HI/LO, computes the result at accept time into
// pending registers and commits it when the latency countdown expires.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  logic [31:0]     r_hi, r_lo;
  logic [31:0]     r_pend_hi, r_pend_lo;
  logic            r_pend_we;
  logic [CntW-1:0] r_cnt;

  logic [31:0]     w_hi_nxt, w_lo_nxt;
  logic [31:0]     w_pend_hi_nxt, w_pend_lo_nxt;
  logic            w_pend_we_nxt;
  logic [CntW-1:0] w_cnt_nxt;

  logic            w_busy;
  logic            w_a_neg, w_b_neg, w_b_zero;
  logic [31:0]     w_a_mag, w_b_mag, w_b_safe, w_b_mag_safe;
  logic [31:0]     w_uq, w_ur, w_sq_mag, w_sr_mag, w_sq, w_sr;
  logic [63:0]     w_prod_s, w_prod_u;

  assign w_busy = (r_cnt != '0);

  // Datapath: full-width results for all four long operations, evaluated from the live operands
  assign w_a_neg  = bus.A[31];
  assign w_b_neg  = bus.B[31];
  assign w_b_zero = (bus.B == 32'd0);
  assign w_a_mag  = w_a_neg ? (32'd0 - bus.A) : bus.A;
  assign w_b_mag  = w_b_neg ? (32'd0 - bus.B) : bus.B;
  // Divisor forced to 1 when zero so the dividers never see x/0; the result is discarded anyway
  assign w_b_safe     = w_b_zero ? 32'd1 : bus.B;
  assign w_b_mag_safe = w_b_zero ? 32'd1 : w_b_mag;

  assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  assign w_uq     = bus.A / w_b_safe;
  assign w_ur     = bus.A % w_b_safe;
  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow and truncates toward zero
  assign w_sq_mag = w_a_mag / w_b_mag_safe;
  assign w_sr_mag = w_a_mag % w_b_mag_safe;
  assign w_sq     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
  assign w_sr     = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;

  // Next-state: countdown/commit while busy, otherwise decode a new command
  always_comb begin
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_we_nxt = r_pend_we;
    w_cnt_nxt     = r_cnt;
    if (w_busy) begin
      w_cnt_nxt = r_cnt - CntW'(1);
      if (r_cnt == CntW'(1) && r_pend_we) begin
        w_hi_nxt = r_pend_hi;
        w_lo_nxt = r_pend_lo;
      end
    end else if (bus.Start) begin
      case (bus.MDUOp)
        OpMult: begin
          {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
          w_pend_we_nxt = 1'b1;
          w_cnt_nxt     = CntW'(MULT_CYCLES);
        end
        OpMultu: begin
          {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
          w_pend_we_nxt = 1'b1;
          w_cnt_nxt     = CntW'(MULT_CYCLES);
        end
        OpDiv: begin
          w_pend_hi_nxt = w_sr;
          w_pend_lo_nxt = w_sq;
          w_pend_we_nxt = !w_b_zero;
          w_cnt_nxt     = CntW'(DIV_CYCLES);
        end
        OpDivu: begin
          w_pend_hi_nxt = w_ur;
          w_pend_lo_nxt = w_uq;
          w_pend_we_nxt = !w_b_zero;
          w_cnt_nxt     = CntW'(DIV_CYCLES);
        end
        OpMthi:  w_hi_nxt = bus.A;
        OpMtlo:  w_lo_nxt = bus.A;
        default: ;
      endcase
    end
  end

  // State registers; synchronous reset also drops any in-flight result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_we <= w_pend_we_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Read port returns committed HI/LO, never the pending result
  always_comb begin
    bus.Out = 32'd0;
    if (bus.Start && bus.MDUOp == OpMfhi) bus.Out = r_hi;
    if (bus.Start && bus.MDUOp == OpMflo) bus.Out = r_lo;
  end

  assign bus.Busy = w_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
